// File: rtl/display_scan.sv
// Eight-digit multiplexed seven-segment scanner. The shown word is latched once per
// frame; a small fetch engine keeps a RAM word up to date for the RAM display mode.
module display_scan #(
  parameter int ADDR_BITS     = 12,
  parameter int SCAN_DIV      = 100000,
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           display_op,
  input  logic [ADDR_BITS-3:0] ram_display_addr,
  input  logic [31:0]          pc,
  input  logic [31:0]          instr,
  input  logic [31:0]          cycle_cnt,
  input  logic [31:0]          jmp_cnt,
  input  logic [31:0]          br_cnt,
  input  logic [31:0]          br_taken_cnt,
  output logic                 mem_rd_req,
  output logic [ADDR_BITS-3:0] mem_addr,
  input  logic [31:0]          mem_rd_data,
  input  logic                 mem_rd_valid,
  output logic [7:0]           an,
  output logic [7:0]           seg,
  output logic                 frame_tick,
  output logic [1:0]           dbg_fetch_state
);

  localparam int AW = ADDR_BITS - 2;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [2:0]      digit_q, digit_d;
  logic [31:0]     shown_q, shown_d;
  logic [31:0]     ram_word_q, ram_word_d;
  logic [31:0]     src_word;
  logic [AW-1:0]   last_addr_q, last_addr_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic [7:0]      an_q, an_d, seg_q, seg_d;
  logic            tick_q, tick_d;
  logic [3:0]      nibble;
  logic            fetch_trig;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  always_comb begin
    case (display_op)
      3'd0:    src_word = pc;
      3'd1:    src_word = instr;
      3'd2:    src_word = ram_word_q;
      3'd3:    src_word = cycle_cnt;
      3'd4:    src_word = jmp_cnt;
      3'd5:    src_word = br_cnt;
      3'd6:    src_word = br_taken_cnt;
      default: src_word = 32'(ram_display_addr);
    endcase
  end

  // Outputs are built from the next-state digit/word so they change on the same edge.
  always_comb begin
    pre_d   = pre_q + 1'b1;
    digit_d = digit_q;
    shown_d = shown_q;
    tick_d  = 1'b0;
    if (pre_q == PRE_LAST) begin
      pre_d   = '0;
      digit_d = digit_q + 3'd1;
      if (digit_q == 3'd7) begin
        shown_d = src_word;
        tick_d  = 1'b1;
      end
    end
    nibble = shown_d[{digit_d, 2'b00} +: 4];
    an_d   = ~(8'd1 << digit_d);
    seg_d  = glyph(nibble);
  end

  // mem_rd_req is a one-cycle strobe with no ready; mem_rd_valid is honoured only
  // while waiting, and the first strobe seen there ends the fetch.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    ram_word_d  = ram_word_q;
    last_addr_d = last_addr_q;
    mem_addr_d  = mem_addr_q;
    fetch_trig  = (tick_q && (display_op == 3'd2)) || (ram_display_addr != last_addr_q);
    case (state_q)
      S_IDLE: begin
        if (fetch_trig) begin
          state_d     = S_REQ;
          mem_addr_d  = ram_display_addr;
          last_addr_d = ram_display_addr;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (mem_rd_valid) begin
          ram_word_d = mem_rd_data;
          state_d    = S_IDLE;
        end else if (wait_q == TO_LAST) begin
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      digit_q     <= '0;
      shown_q     <= '0;
      ram_word_q  <= '0;
      last_addr_q <= '0;
      mem_addr_q  <= '0;
      wait_q      <= '0;
      an_q        <= 8'hFF;
      seg_q       <= 8'hFF;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      digit_q     <= digit_d;
      shown_q     <= shown_d;
      ram_word_q  <= ram_word_d;
      last_addr_q <= last_addr_d;
      mem_addr_q  <= mem_addr_d;
      wait_q      <= wait_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      tick_q      <= tick_d;
    end
  end

  assign mem_rd_req      = (state_q == S_REQ);
  assign mem_addr        = mem_addr_q;
  assign an              = an_q;
  assign seg             = seg_q;
  assign frame_tick      = tick_q;
  assign dbg_fetch_state = state_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: directed scenarios with literal expectations plus a random
// phase, all outputs compared every cycle against a timestamp-based behavioural model.
module tb_display_scan;
  localparam int AB    = 12;
  localparam int AW    = AB - 2;
  localparam int D     = 4;
  localparam int FT    = 16;
  localparam int FRAME = 8 * D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    display_op = 3'd0;
  logic [AW-1:0] ram_display_addr = '0;
  logic [31:0]   pc = 32'h1234ABCD, instr = 32'h0, cycle_cnt = 32'h0;
  logic [31:0]   jmp_cnt = 32'h0, br_cnt = 32'h0, br_taken_cnt = 32'h0;
  logic          mem_rd_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rd_data;
  logic          mem_rd_valid;
  logic [7:0]    an, seg;
  logic          frame_tick;
  logic [1:0]    dbg_fetch_state;

  display_scan #(.ADDR_BITS(AB), .SCAN_DIV(D), .FETCH_TIMEOUT(FT)) dut (
    .clk(clk), .rst_n(rst_n), .display_op(display_op), .ram_display_addr(ram_display_addr),
    .pc(pc), .instr(instr), .cycle_cnt(cycle_cnt), .jmp_cnt(jmp_cnt), .br_cnt(br_cnt),
    .br_taken_cnt(br_taken_cnt), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .an(an), .seg(seg),
    .frame_tick(frame_tick), .dbg_fetch_state(dbg_fetch_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [7:0] gly [16];
  logic [7:0] exp_pc [8];
  initial begin
    gly = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    exp_pc = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  end

  // Behavioural model: m_n counts edges since reset release; the scan position and
  // frame boundaries follow arithmetically, and a fetch is tracked by its start edge.
  int            m_n = 0;
  int            m_req_at = 0;
  logic          m_busy = 1'b0;
  logic          m_tick = 1'b0;
  logic [31:0]   m_shown = '0, m_ram = '0;
  logic [AW-1:0] m_last = '0, m_addr = '0;

  function automatic logic [31:0] src(input logic [2:0] op);
    case (op)
      3'd0: return pc;
      3'd1: return instr;
      3'd2: return m_ram;
      3'd3: return cycle_cnt;
      3'd4: return jmp_cnt;
      3'd5: return br_cnt;
      3'd6: return br_taken_cnt;
      default: return 32'(ram_display_addr);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int   nn;
    logic old_tick;
    if (!rst_n) begin
      m_n = 0; m_req_at = 0; m_busy = 1'b0; m_tick = 1'b0;
      m_shown = '0; m_ram = '0; m_last = '0; m_addr = '0;
    end else begin
      nn = m_n + 1;
      old_tick = m_tick;
      m_tick = 1'b0;
      if (nn % FRAME == 0) begin
        m_shown = src(display_op);
        m_tick  = 1'b1;
      end
      if (m_busy) begin
        if (mem_rd_valid && (nn - m_req_at >= 2)) begin
          m_ram  = mem_rd_data;
          m_busy = 1'b0;
        end else if (nn - m_req_at == FT + 1) begin
          m_busy = 1'b0;
        end
      end else if ((old_tick && display_op == 3'd2) || (ram_display_addr != m_last)) begin
        m_busy   = 1'b1;
        m_req_at = nn;
        m_addr   = ram_display_addr;
        m_last   = ram_display_addr;
      end
      m_n = nn;
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    logic [7:0] ea, es;
    int dg;
    if (m_n == 0) begin
      ea = 8'hFF; es = 8'hFF;
    end else begin
      dg = (m_n / D) % 8;
      ea = ~(8'h01 << dg);
      es = gly[m_shown[4*dg +: 4]];
    end
    check("model_an", an, ea);
    check("model_seg", seg, es);
    check("model_tick", frame_tick, m_tick);
    check("model_req", mem_rd_req, m_busy && (m_n == m_req_at));
    check("model_addr", mem_addr, m_addr);
  end

  // RAM responder: mode 0 silent, 1 fixed latency/data, 2 random latency/data
  int          resp_mode = 0;
  int          fix_lat = 3;
  logic [31:0] fix_data = 32'h0;
  logic        spur_en = 1'b0;
  int          resp_cnt = 0;
  logic [31:0] resp_data = 32'h0;

  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = 32'h0;
    forever begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      mem_rd_data  = $urandom;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = resp_data;
        end
      end else if (spur_en && $urandom_range(0, 29) == 0) begin
        mem_rd_valid = 1'b1;
      end
      if (mem_rd_req === 1'b1 && resp_mode == 1) begin
        resp_cnt = fix_lat; resp_data = fix_data;
      end else if (mem_rd_req === 1'b1 && resp_mode == 2) begin
        resp_cnt = $urandom_range(1, 20); resp_data = $urandom;
      end
    end
  end

  // driver tasks with bounded waits
  task automatic wait_tick(input string nm);
    int i;
    i = 0;
    do begin @(negedge clk); i++; end while (frame_tick !== 1'b1 && i < 300);
    check(nm, frame_tick, 1'b1);
  endtask

  task automatic wait_req(input string nm, input int limit);
    int i;
    i = 0;
    do begin @(negedge clk); i++; end while (mem_rd_req !== 1'b1 && i < limit);
    check(nm, mem_rd_req, 1'b1);
  endtask

  task automatic wait_an(input logic [7:0] want, input string nm);
    int i;
    i = 0;
    while (an !== want && i < 100) begin @(negedge clk); i++; end
    check(nm, an, want);
  endtask

  task automatic check_digit(input int k, input logic [7:0] want, input string nm);
    wait_an(~(8'h01 << k), {nm, "_an"});
    check(nm, seg, want);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 8'hFF);
    check("rst_req", mem_rd_req, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_an", an, 8'hFE);
    check("first_seg", seg, 8'hC0);

    // pc shown from the second frame on
    wait_tick("pc_tick");
    for (int k = 0; k < 8; k++) check_digit(k, exp_pc[k], "pc_digit");

    // RAM word display with a 3-cycle read latency
    resp_mode = 1; fix_lat = 3; fix_data = 32'hDEADBEEF;
    @(negedge clk);
    display_op = 3'd2; ram_display_addr = 10'd5;
    wait_req("ram_req", 40);
    check("ram_req_addr", mem_addr, 32'd5);
    @(negedge clk);
    check("ram_req_one_cycle", mem_rd_req, 1'b0);
    wait_tick("ram_tick1");
    wait_tick("ram_tick2");
    check_digit(0, 8'h8E, "ram_d0");
    check_digit(7, 8'hA1, "ram_d7");

    // address change fetches without a frame boundary
    fix_lat = 2; fix_data = 32'hCAFEF00D;
    @(negedge clk);
    display_op = 3'd3; cycle_cnt = 32'h0BADF00D; ram_display_addr = 10'd9;
    wait_req("addr_req", 40);
    check("addr_req_addr", mem_addr, 32'd9);
    wait_tick("cyc_tick");
    check_digit(0, 8'hA1, "cyc_d0");
    check_digit(7, 8'hC0, "cyc_d7");

    // RAM never answers: ram_word kept, next op-2 frame re-requests
    resp_mode = 0;
    @(negedge clk);
    display_op = 3'd2;
    wait_tick("to_tick1");
    wait_req("to_req1", 4);
    wait_tick("to_tick2");
    wait_req("to_req2", 4);
    check_digit(0, 8'hA1, "to_d0");
    check_digit(7, 8'hC6, "to_d7");

    // reset during a pending read
    resp_mode = 1; fix_lat = 10; fix_data = 32'h11111111;
    wait_tick("rw_tick");
    wait_req("rw_req", 4);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rw_an", an, 8'hFF);
    check("rw_seg", seg, 8'hFF);
    check("rw_req", mem_rd_req, 1'b0);
    resp_mode = 0; ram_display_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rw_first_an", an, 8'hFE);
    check("rw_first_seg", seg, 8'hC0);
    wait_tick("rw_tick1");
    wait_tick("rw_tick2");
    check_digit(0, 8'hC0, "rw_d0");
    check_digit(7, 8'hC0, "rw_d7");

    // op change mid-frame waits for the boundary
    @(negedge clk);
    display_op = 3'd0; pc = 32'h89ABCDEF; ram_display_addr = 10'h2A;
    wait_tick("op_tick1");
    wait_an(8'hF7, "op_d3_an");
    display_op = 3'd7;
    check_digit(5, 8'h88, "op_old_d5");
    wait_tick("op_tick2");
    for (int k = 0; k < 8; k++)
      check_digit(k, (k == 0) ? 8'h88 : (k == 1) ? 8'hA4 : 8'hC0, "op_new_digit");

    // random phase
    resp_mode = 2; spur_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) display_op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) ram_display_addr = AW'($urandom_range(0, 3));
      if (c % 8 == 0) begin
        pc = $urandom; instr = $urandom; cycle_cnt = $urandom;
        jmp_cnt = $urandom; br_cnt = $urandom; br_taken_cnt = $urandom;
      end
      if (c == 1100 || c == 2300) begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
